video_timing_gen: RTL and testbench
===================================

# video_timing_gen

- Generates raster timing for the HDMI/DVI output path: horizontal/vertical counters, sync pulses, active-video indicator and pixel coordinates.
- Sits directly upstream of the three per-channel TMDS encoders.
  - `active` feeds every encoder.
  - `ctl` feeds the blue-channel encoder.
  - `x`/`y` feed the renderer that produces pixel data.
- An optional built-in colour-bar generator supplies pixel data for bring-up without the renderer.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level (0 = active-low)

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- hsync  out  1  horizontal sync, polarity per H_POL
- vsync  out  1  vertical sync, polarity per V_POL
- ctl  out  2  {vsync, hsync}, same values as the sync outputs; encoder control input
- active  out  1  high during visible pixels
- x  out  12  horizontal counter value
- y  out  12  vertical counter value
- line_start  out  1  one-cycle pulse at h_cnt == 0
- frame_start  out  1  one-cycle pulse at h_cnt == 0 && v_cnt == 0
- r, g, b  out  8 each  test-pattern pixel data

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be ≤ 4096.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments when h_cnt wraps; v_cnt wraps to 0 at V_TOTAL-1.
- Region order per line and per frame: active, front porch, sync, back porch.
- hsync is asserted (level = H_POL) iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. Otherwise it is at the idle level ~H_POL.
- vsync is asserted (level = V_POL) iff V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - It switches only at line boundaries (h_cnt == 0), never mid-line.
- active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- x = h_cnt and y = v_cnt, as raw counter values. They are meaningful only while active is high.
- ctl[0] = hsync and ctl[1] = vsync, including polarity.
- All outputs are registered. There is no combinational path from a counter to any port.

## Timing
- Latency is one cycle: outputs in cycle n+1 reflect counter state in cycle n. All outputs are mutually aligned.
- Reset (rst_n low at a pixel_clk edge):
  - counters = 0
  - hsync = ~H_POL, vsync = ~V_POL, ctl = {~V_POL, ~H_POL}
  - active = 0, x = 0, y = 0, line_start = 0, frame_start = 0
  - r = g = b = 0
- First cycle after rst_n rises: counter is (0,0), so outputs in the following cycle show active = 1, line_start = 1, frame_start = 1, x = y = 0.
- Reset asserted mid-frame: reset values apply at the next edge with no completion of the current line. The frame restarts cleanly.
- frame_start period is H_TOTAL*V_TOTAL cycles; line_start period is H_TOTAL cycles.
- Wrap-around at (H_TOTAL-1, V_TOTAL-1) returns to (0,0) in one cycle, with no idle cycle.

## Configuration
- Macro: VIDEO_TIMING_TEST_PATTERN_EN.
- Defined: r/g/b output 8 vertical colour bars of width BW = H_ACTIVE/8 (integer division).
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Any remainder pixels belong to bar 7.
  - Bar index comes from a per-line bar counter reset at h_cnt == 0, not from a divider.
  - r/g/b = 0 whenever active is low.
  - r/g/b are registered and aligned with active.
- Undefined: r/g/b are constant 0, and no bar logic is synthesized.

## Test plan
- Reset: hold rst_n low 5 cycles -> every output at its reset value. Release -> frame_start = 1, active = 1, x = y = 0 two cycles later.
- Default parameters, one full frame -> consecutive frame_start pulses exactly 420000 cycles apart; active high for exactly 307200 cycles per frame.
- Horizontal timing, line 0 -> active high for x = 0..639; hsync low for exactly 96 cycles with first low at x = 656; line_start every 800 cycles.
- Vertical timing -> vsync low only for y = 490 and 491, changing coincident with x = 0; ctl == {vsync, hsync} on every cycle.
- Mid-frame reset at y = 300, x = 200 -> next cycle holds reset values. After release, timing restarts from (0,0) with a full 420000-cycle frame.
- With VIDEO_TIMING_TEST_PATTERN_EN:
  - x = 79 -> FFFFFF; x = 80 -> FFFF00; x = 639 -> 000000.
  - x = 700 -> r/g/b = 0.
  - Without the macro, r/g/b = 0 throughout.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing for the HDMI/DVI output path.
// Produces h/v counters, sync pulses, active-video flag, pixel coordinates
// and line/frame start strobes, all registered and mutually aligned.
// Optional colour-bar test pattern: define VIDEO_TIMING_TEST_PATTERN_EN.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  output logic        hsync,
  output logic        vsync,
  output logic [1:0]  ctl,
  output logic        active,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam int unsigned CW      = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Region boundaries, one bit wider than the counters so an end value of
  // exactly 4096 still compares correctly.
  localparam logic [CW:0]   H_ACT_END   = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0]   H_SYNC_BEG  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   H_SYNC_END  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   V_ACT_END   = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0]   V_SYNC_BEG  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   V_SYNC_END  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST      = CW'(V_TOTAL - 1);

  logic [CW-1:0] h_cnt, v_cnt;
  logic [CW-1:0] h_nxt, v_nxt;
  logic [CW:0]   h_ext, v_ext;
  logic          h_wrap;
  logic          hs_on, vs_on, act_c, ls_c, fs_c;
  logic          hs_lvl, vs_lvl;

  // Next counter values: h wraps at H_TOTAL-1, v advances on h wrap.
  always_comb begin
    h_wrap = (h_cnt == H_LAST);
    h_nxt  = h_cnt + CW'(1);
    v_nxt  = v_cnt;
    if (h_wrap) begin
      h_nxt = '0;
      if (v_cnt == V_LAST) v_nxt = '0;
      else                 v_nxt = v_cnt + CW'(1);
    end
  end

  // Region decode of the current counter state; feeds the output registers only.
  always_comb begin
    h_ext  = {1'b0, h_cnt};
    v_ext  = {1'b0, v_cnt};
    hs_on  = (h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END);
    vs_on  = (v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END);
    act_c  = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    ls_c   = (h_cnt == '0);
    fs_c   = (h_cnt == '0) && (v_cnt == '0);
    hs_lvl = hs_on ? H_POL : ~H_POL;
    vs_lvl = vs_on ? V_POL : ~V_POL;
  end

  // Raster counters.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  // Timing outputs, one cycle behind the counters.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      ctl         <= {~V_POL, ~H_POL};
      active      <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= hs_lvl;
      vsync       <= vs_lvl;
      ctl         <= {vs_lvl, hs_lvl};
      active      <= act_c;
      x           <= h_cnt;
      y           <= v_cnt;
      line_start  <= ls_c;
      frame_start <= fs_c;
    end
  end

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  // Bar width; a degenerate H_ACTIVE < 8 collapses to 1-pixel bars.
  localparam int unsigned   BW      = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;
  localparam logic [CW-1:0] BW_LAST = CW'(BW - 1);

  logic [CW-1:0] bar_pos, bar_pos_nxt;
  logic [2:0]    bar_idx, bar_idx_nxt;

  // Bar tracker advances with h_cnt; bar 7 absorbs any remainder pixels.
  always_comb begin
    bar_pos_nxt = bar_pos;
    bar_idx_nxt = bar_idx;
    if (h_wrap) begin
      bar_pos_nxt = '0;
      bar_idx_nxt = '0;
    end else if (bar_idx != 3'd7) begin
      if (bar_pos == BW_LAST) begin
        bar_pos_nxt = '0;
        bar_idx_nxt = bar_idx + 3'd1;
      end else begin
        bar_pos_nxt = bar_pos + CW'(1);
      end
    end
  end

  // Bar tracker state, aligned with h_cnt.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      bar_pos <= '0;
      bar_idx <= '0;
    end else begin
      bar_pos <= bar_pos_nxt;
      bar_idx <= bar_idx_nxt;
    end
  end

  // Colour lookup: white, yellow, cyan, green, magenta, red, blue, black
  // maps to r = ~idx[1], g = ~idx[2], b = ~idx[0]; blanked outside active.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else if (act_c) begin
      r <= {8{~bar_idx[1]}};
      g <= {8{~bar_idx[2]}};
      b <= {8{~bar_idx[0]}};
    end else begin
      r <= '0;
      g <= '0;
      b <= '0;
    end
  end
`else
  // No test pattern: pixel data tied low.
  assign r = '0;
  assign g = '0;
  assign b = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced raster:
// H: 20 active + 2 fp + 3 sync + 4 bp = 29; V: 6 active + 1 fp + 2 sync + 2 bp = 11.
// Frame = 319 cycles, 120 active pixels, bar width 2 with 4 remainder pixels.
module tb_video_timing_gen;

  localparam int unsigned HA = 20, HF = 2, HS = 3, HB = 4;
  localparam int unsigned VA = 6,  VF = 1, VS = 2, VB = 2;

  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        hsync, vsync, active, line_start, frame_start;
  logic [1:0]  ctl;
  logic [11:0] x, y;
  logic [7:0]  r, g, b;

  int total = 0;
  int bad   = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n),
    .hsync(hsync), .vsync(vsync), .ctl(ctl), .active(active),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
    .r(r), .g(g), .b(b)
  );

  always #5 pixel_clk = ~pixel_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic wait_xy(input int wx, input int wy, input string nm);
    int n = 0;
    while (!(x == 12'(wx) && y == 12'(wy)) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL %s: timeout waiting for x=%0d y=%0d (at x=%0d y=%0d)", nm, wx, wy, x, y);
    end
  endtask

  task automatic check_reset_values(input string nm);
    total++;
    if (hsync !== 1'b1 || vsync !== 1'b1 || ctl !== 2'b11 || active !== 1'b0 ||
        x !== 12'd0 || y !== 12'd0 || line_start !== 1'b0 || frame_start !== 1'b0 ||
        {r, g, b} !== 24'h0) begin
      bad++;
      $display("FAIL %s: got hs=%b vs=%b ctl=%b act=%b x=%0d y=%0d ls=%b fs=%b rgb=%h, want 1 1 11 0 0 0 0 0 000000",
               nm, hsync, vsync, ctl, active, x, y, line_start, frame_start, {r, g, b});
    end
  endtask

  task automatic check_first_pixel(input string nm);
    total++;
    if (frame_start !== 1'b1 || line_start !== 1'b1 || active !== 1'b1 ||
        x !== 12'd0 || y !== 12'd0 || hsync !== 1'b1 || vsync !== 1'b1) begin
      bad++;
      $display("FAIL %s: got fs=%b ls=%b act=%b x=%0d y=%0d hs=%b vs=%b, want 1 1 1 0 0 1 1",
               nm, frame_start, line_start, active, x, y, hsync, vsync);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) tick();
    check_reset_values("reset_hold");
    rst_n = 1'b1;
    tick();
    check_first_pixel("reset_release");
  endtask

  task automatic test_horizontal();
    int act = 0, hl = 0, ls = 0, first_low = -1;
    wait_xy(0, 0, "horiz_sync");
    for (int i = 0; i < 29; i++) begin
      if (active) act++;
      if (!hsync) begin
        if (first_low < 0) first_low = int'(x);
        hl++;
      end
      if (line_start) ls++;
      tick();
    end
    total++; if (act != 20) begin bad++; $display("FAIL h_active_count: got %0d want 20", act); end
    total++; if (hl != 3) begin bad++; $display("FAIL hsync_width: got %0d want 3", hl); end
    total++; if (first_low != 22) begin bad++; $display("FAIL hsync_first_x: got %0d want 22", first_low); end
    total++; if (ls != 1) begin bad++; $display("FAIL line_start_in_line: got %0d want 1", ls); end
    total++;
    if (line_start !== 1'b1 || x !== 12'd0 || y !== 12'd1) begin
      bad++;
      $display("FAIL line_period: got ls=%b x=%0d y=%0d want ls=1 x=0 y=1", line_start, x, y);
    end
  endtask

  task automatic test_vertical();
    int vl = 0, trans = 0, bad_edge = 0, ctl_bad = 0, ymin = 99, ymax = -1;
    int last_x = -1, last_y = -1;
    logic prev_vs;
    wait_xy(0, 0, "vert_sync");
    prev_vs = vsync;
    for (int i = 0; i < 319; i++) begin
      if (vsync !== prev_vs) begin
        trans++;
        if (x !== 12'd0) bad_edge++;
      end
      prev_vs = vsync;
      if (!vsync) begin
        vl++;
        if (int'(y) < ymin) ymin = int'(y);
        if (int'(y) > ymax) ymax = int'(y);
      end
      if (ctl !== {vsync, hsync}) ctl_bad++;
      if (i == 318) begin last_x = int'(x); last_y = int'(y); end
      tick();
    end
    total++; if (vl != 58) begin bad++; $display("FAIL vsync_low_cycles: got %0d want 58", vl); end
    total++; if (ymin != 7 || ymax != 8) begin bad++; $display("FAIL vsync_lines: got %0d..%0d want 7..8", ymin, ymax); end
    total++; if (trans != 2) begin bad++; $display("FAIL vsync_transitions: got %0d want 2", trans); end
    total++; if (bad_edge != 0) begin bad++; $display("FAIL vsync_midline: got %0d edges off x=0 want 0", bad_edge); end
    total++; if (ctl_bad != 0) begin bad++; $display("FAIL ctl_match: got %0d mismatching cycles want 0", ctl_bad); end
    total++;
    if (last_x != 28 || last_y != 10 || frame_start !== 1'b1 || x !== 12'd0 || y !== 12'd0) begin
      bad++;
      $display("FAIL wrap: got last=(%0d,%0d) then fs=%b (%0d,%0d) want (28,10) then 1 (0,0)",
               last_x, last_y, frame_start, x, y);
    end
  endtask

  task automatic test_frame();
    int act = 0, ls = 0, fs = 0;
    wait_xy(0, 0, "frame_sync");
    for (int i = 0; i < 319; i++) begin
      if (active) act++;
      if (line_start) ls++;
      if (frame_start) fs++;
      tick();
    end
    total++; if (act != 120) begin bad++; $display("FAIL frame_active: got %0d want 120", act); end
    total++; if (ls != 11) begin bad++; $display("FAIL frame_lines: got %0d want 11", ls); end
    total++; if (fs != 1) begin bad++; $display("FAIL frame_start_count: got %0d want 1", fs); end
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL frame_period: got fs=%b after 319 cycles want 1", frame_start); end
  endtask

`ifdef VIDEO_TIMING_TEST_PATTERN_EN
  task automatic test_pattern();
    int     px[7]  = '{0, 1, 2, 12, 13, 16, 19};
    logic [23:0] ex[7] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h0000FF,
                            24'h0000FF, 24'h000000, 24'h000000};
    for (int k = 0; k < 7; k++) begin
      wait_xy(px[k], 1, "bar_sync");
      total++;
      if ({r, g, b} !== ex[k]) begin
        bad++;
        $display("FAIL bar_x%0d: got %h want %h", px[k], {r, g, b}, ex[k]);
      end
    end
    wait_xy(24, 1, "blank_sync");
    total++;
    if ({r, g, b} !== 24'h0) begin bad++; $display("FAIL bar_hblank: got %h want 000000", {r, g, b}); end
    wait_xy(5, 8, "vblank_sync");
    total++;
    if ({r, g, b} !== 24'h0) begin bad++; $display("FAIL bar_vblank: got %h want 000000", {r, g, b}); end
  endtask
`else
  task automatic test_pattern();
    int nz = 0;
    for (int i = 0; i < 319; i++) begin
      if ({r, g, b} !== 24'h0) nz++;
      tick();
    end
    total++;
    if (nz != 0) begin bad++; $display("FAIL rgb_zero: got %0d nonzero cycles want 0", nz); end
  endtask
`endif

  task automatic test_mid_reset();
    int n = 0;
    wait_xy(10, 4, "midreset_sync");
    rst_n = 1'b0;
    tick();
    check_reset_values("midreset_hold");
    rst_n = 1'b1;
    tick();
    check_first_pixel("midreset_release");
    do begin
      tick();
      n++;
    end while (frame_start !== 1'b1 && n < 2000);
    total++;
    if (n != 319) begin bad++; $display("FAIL midreset_frame_len: got %0d want 319", n); end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_vertical();
    test_frame();
    test_pattern();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
